dot_batch_ctrl: RTL

Batch scheduler for the `naive_dot` engine. It accepts a job descriptor (base row, row count), fetches one weight/activation row pair per cycle from a 1-cycle-latency row memory, and issues one `start` per row to the engine. It collects each `done`/`result` into an output FIFO with a valid/ready handshake. Credit-based issue guarantees the FIFO never overflows, whatever the engine latency or downstream backpressure.

---
 rtl/dot_batch_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/dot_batch_ctrl.sv
// Batch scheduler for the naive_dot engine: row fetch, credit-gated issue and an in-order result FIFO.
// Defining DOT_BATCH_CTRL_PERF_EN adds saturating busy/stall performance counters.
module dot_batch_ctrl #(
    parameter int N            = 128,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACT_WIDTH    = 4,
    parameter int RES_WIDTH    = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_WIDTH-1:0]       cmd_base,
    input  logic [ADDR_WIDTH:0]         cmd_len,
    output logic                        mem_rd_en,
    output logic [ADDR_WIDTH-1:0]       mem_rd_addr,
    input  logic [N*WEIGHT_WIDTH-1:0]   mem_rd_weights,
    input  logic [N*ACT_WIDTH-1:0]      mem_rd_acts,
    output logic                        dot_start,
    output logic [N*WEIGHT_WIDTH-1:0]   dot_weights_flat,
    output logic [N*ACT_WIDTH-1:0]      dot_acts_flat,
    input  logic                        dot_done,
    input  logic signed [RES_WIDTH-1:0] dot_result,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic signed [RES_WIDTH-1:0] res_data,
    output logic                        busy,
    output logic                        job_done,
    output logic                        err_unexp_done,
    output logic [31:0]                 perf_busy_cycles,
    output logic [31:0]                 perf_stall_cycles
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int KW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e                      state_q;
    logic [ADDR_WIDTH-1:0]       base_q;
    logic [CW-1:0]               len_q;
    logic [CW-1:0]               issued_q;
    logic [CW-1:0]               received_q;
    logic                        cmd_ready_q;
    logic                        busy_q;
    logic                        job_done_q;
    logic                        dot_start_q;
    logic                        err_q;
    logic [KW-1:0]               credits_q;
    logic [KW-1:0]               count_q;
    logic [PW-1:0]               wr_ptr_q;
    logic [PW-1:0]               rd_ptr_q;
    logic signed [RES_WIDTH-1:0] fifo_q [FIFO_DEPTH];

    logic          accept;
    logic          rd_en;
    logic          push;
    logic          pop;
    logic          last_issue;
    logic          last_recv;
    logic [CW-1:0] outstanding;

    // cmd_ready_q is only high in IDLE, so it doubles as the state qualifier for accepting a job.
    assign accept      = cmd_ready_q && cmd_valid;
    assign rd_en       = (state_q == ISSUE) && (credits_q != '0) && (issued_q < len_q);
    assign outstanding = issued_q - received_q;
    assign push        = dot_done && (outstanding != '0);
    assign pop         = (count_q != '0) && res_ready;
    assign last_issue  = rd_en && ((issued_q + CW'(1)) == len_q);
    assign last_recv   = push && ((received_q + CW'(1)) == len_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            job_done_q  <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            if (rd_en) begin
                issued_q <= issued_q + CW'(1);
            end
            if (push) begin
                received_q <= received_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        base_q     <= cmd_base;
                        len_q      <= cmd_len;
                        issued_q   <= '0;
                        received_q <= '0;
                        if (cmd_len == '0) begin
                            job_done_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_recv) begin
                        state_q     <= IDLE;
                        job_done_q  <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Each credit reserves one FIFO slot from issue until the matching result is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q <= KW'(FIFO_DEPTH);
        end else begin
            case ({rd_en, pop})
                2'b10:   credits_q <= credits_q - KW'(1);
                2'b01:   credits_q <= credits_q + KW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_start_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            dot_start_q <= rd_en;
            if (dot_done && (outstanding == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: the FIFO storage is reset as well, because res_data must read 0 after reset and
    // a mid-job reset has to discard stale results; at this depth the cost is negligible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= dot_result;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + KW'(1);
                2'b01:   count_q <= count_q - KW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef DOT_BATCH_CTRL_PERF_EN
    logic [31:0] busy_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall;

    assign stall = (state_q == ISSUE) && (issued_q < len_q) && (credits_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (busy_q && (busy_cnt_q != 32'hFFFF_FFFF)) begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles  = busy_cnt_q;
    assign perf_stall_cycles = stall_cnt_q;
`else
    assign perf_busy_cycles  = '0;
    assign perf_stall_cycles = '0;
`endif

    assign cmd_ready        = cmd_ready_q;
    assign busy             = busy_q;
    assign job_done         = job_done_q;
    assign err_unexp_done   = err_q;
    assign mem_rd_en        = rd_en;
    assign mem_rd_addr      = base_q + issued_q[ADDR_WIDTH-1:0];
    assign dot_start        = dot_start_q;
    assign dot_weights_flat = dot_start_q ? mem_rd_weights : '0;
    assign dot_acts_flat    = dot_start_q ? mem_rd_acts : '0;
    assign res_valid        = (count_q != '0);
    assign res_data         = fifo_q[rd_ptr_q];

endmodule
